// File: rtl/re_rnd_clip_if.sv
// re_rnd_clip_if: beat-level bus between the butterfly network, the normaliser and its consumers.
interface re_rnd_clip_if;
    logic         i_inverse;
    logic         i_stage;
    logic [1:0]   i_transize;
    logic         i_dt_vld;
    logic [895:0] i_data;
    logic         o_dt_vld;
    logic [511:0] o_data;
    logic         o_first;
    logic         o_last;
    logic         o_zero;
    logic         o_sat;
    modport master (
        output i_inverse, i_stage, i_transize, i_dt_vld, i_data,
        input  o_dt_vld, o_data, o_first, o_last, o_zero, o_sat
    );
    modport slave (
        input  i_inverse, i_stage, i_transize, i_dt_vld, i_data,
        output o_dt_vld, o_data, o_first, o_last, o_zero, o_sat
    );
endinterface

// File: rtl/re_rnd_clip.sv
// re_rnd_clip: stage-dependent rounding right-shift and 16-bit saturation of 32 butterfly lanes,
// with beat tracking inside the transform block.
module re_rnd_clip #(
    parameter int BIT_DEPTH = 8,
    parameter int LANES     = 32
) (
    input logic          clk,
    input logic          rst_n,
    re_rnd_clip_if.slave bus
);
    logic [4:0] cnt_q, cnt_d;
    logic inv_q, stg_q;
    logic [1:0] ts_q, ts;
    logic start, inv, stg, last_d;
    logic [5:0] bpb;
    logic [3:0] l, s_d, s_q;
    logic [LANES-1:0][28:0] sum_d, sum_q, q_v;
    logic [LANES-1:0] ovf_v, sat_v;
    logic [16*LANES-1:0] data_d, data_q;
    logic vld1_q, first1_q, last1_q, sm1_q;
    logic vld_q, first_q, last_q, zero_q, sat_q;

    // The first beat of a block uses the live config; later beats use the latched copy.
    always_comb begin
        start  = cnt_q == 5'd0;
        inv    = start ? bus.i_inverse : inv_q;
        stg    = start ? bus.i_stage : stg_q;
        ts     = start ? bus.i_transize : ts_q;
        bpb    = ts == 2'd0 ? 6'd1 : ts == 2'd1 ? 6'd2 : ts == 2'd2 ? 6'd8 : 6'd32;
        last_d = bus.i_dt_vld && {1'b0, cnt_q} == bpb - 6'd1;
        cnt_d  = !bus.i_dt_vld ? cnt_q : last_d ? 5'd0 : cnt_q + 5'd1;
        l      = {2'b00, ts} + 4'd2;
        s_d    = inv ? (stg ? 4'(20 - BIT_DEPTH) : 4'd7) : (stg ? l + 4'd6 : l + 4'(BIT_DEPTH - 9));
    end

    // Lanes in the upper half are forced to zero and ignored for saturation in 4x4 mode.
    always_comb begin
        sum_d  = '0;
        q_v    = '0;
        ovf_v  = '0;
        sat_v  = '0;
        data_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d[k] = {bus.i_data[28*k+27], bus.i_data[28*k +: 28]} + (29'd1 << (s_d - 4'd1));
            q_v[k]   = 29'($signed(sum_q[k]) >>> s_q);
            ovf_v[k] = q_v[k][28:15] != {14{q_v[k][15]}};
            sat_v[k] = ovf_v[k] && !(sm1_q && k >= LANES / 2);
            data_d[16*k +: 16] = (sm1_q && k >= LANES / 2) ? 16'h0000 :
                                 ovf_v[k] ? (q_v[k][28] ? 16'h8000 : 16'h7fff) : q_v[k][15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            inv_q    <= 1'b0;
            stg_q    <= 1'b0;
            ts_q     <= '0;
            vld1_q   <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            sm1_q    <= 1'b0;
            s_q      <= '0;
            sum_q    <= '0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            zero_q   <= 1'b0;
            sat_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (bus.i_dt_vld && start) begin
                inv_q <= bus.i_inverse;
                stg_q <= bus.i_stage;
                ts_q  <= bus.i_transize;
            end
            vld1_q   <= bus.i_dt_vld;
            first1_q <= bus.i_dt_vld && start;
            last1_q  <= last_d;
            if (bus.i_dt_vld) begin
                sum_q <= sum_d;
                s_q   <= s_d;
                sm1_q <= ts == 2'd0;
            end
            vld_q   <= vld1_q;
            first_q <= vld1_q && first1_q;
            last_q  <= vld1_q && last1_q;
            zero_q  <= vld1_q && data_d == '0;
            sat_q   <= vld1_q && |sat_v;
            if (vld1_q) data_q <= data_d;
        end
    end

    assign bus.o_dt_vld = vld_q;
    assign bus.o_data   = data_q;
    assign bus.o_first  = first_q;
    assign bus.o_last   = last_q;
    assign bus.o_zero   = zero_q;
    assign bus.o_sat    = sat_q;
endmodule

// File: tb/tb_re_rnd_clip.sv
// tb_re_rnd_clip: directed checks of rounding, saturation, lane masking and beat flags at 8- and 10-bit depth.
module tb_re_rnd_clip;
    logic clk = 1'b0;
    logic rst_n;
    int errors = 0;
    int checks = 0;
    logic [895:0] d;
    logic [511:0] e;
    logic [0:11] v_t  = 12'b111101110100;
    logic [0:11] big_t = 12'b110000000000;
    logic [0:11] f_t  = 12'b100000000000;
    logic [0:11] l_t  = 12'b000000000100;

    re_rnd_clip_if bus8 ();
    re_rnd_clip_if bus10 ();

    re_rnd_clip #(.BIT_DEPTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    re_rnd_clip #(.BIT_DEPTH(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv8(input logic v, input logic inv, input logic stg, input logic [1:0] ts, input logic [895:0] dd);
        bus8.i_dt_vld   = v;
        bus8.i_inverse  = inv;
        bus8.i_stage    = stg;
        bus8.i_transize = ts;
        bus8.i_data     = dd;
    endtask

    task automatic drv10(input logic v, input logic inv, input logic stg, input logic [1:0] ts, input logic [895:0] dd);
        bus10.i_dt_vld   = v;
        bus10.i_inverse  = inv;
        bus10.i_stage    = stg;
        bus10.i_transize = ts;
        bus10.i_data     = dd;
    endtask

    task automatic flags8(input string tag, input logic f, input logic l, input logic z, input logic s);
        check({tag, "_vld"}, bus8.o_dt_vld, 1'b1);
        check({tag, "_first"}, bus8.o_first, f);
        check({tag, "_last"}, bus8.o_last, l);
        check({tag, "_zero"}, bus8.o_zero, z);
        check({tag, "_sat"}, bus8.o_sat, s);
    endtask

    initial begin
        rst_n = 1'b0;
        drv8(1'b0, 1'b0, 1'b0, 2'd0, '0);
        drv10(1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick;
        tick;
        check("rst_vld", bus8.o_dt_vld, 1'b0);
        check("rst_data", bus8.o_data, '0);
        check("rst_flags", {bus8.o_first, bus8.o_last, bus8.o_zero, bus8.o_sat}, 4'b0);
        check("rst10_vld", bus10.o_dt_vld, 1'b0);
        rst_n = 1'b1;
        tick;

        // 32x32 DCT stage0, S=4: 24 -> 2
        for (int i = 0; i < 34; i++) begin
            drv8(i < 32, 1'b0, 1'b0, 2'd3, {32{28'd24}});
            tick;
            if (i == 0) check("b32_lat", bus8.o_dt_vld, 1'b0);
            if (i >= 1 && i <= 32) begin
                check("b32_vld", bus8.o_dt_vld, 1'b1);
                check("b32_data", bus8.o_data, {32{16'd2}});
                check("b32_first", bus8.o_first, i == 1);
                check("b32_last", bus8.o_last, i == 32);
            end
            if (i == 33) begin
                check("b32_idle_vld", bus8.o_dt_vld, 1'b0);
                check("b32_idle_flags", {bus8.o_first, bus8.o_last, bus8.o_zero, bus8.o_sat}, 4'b0);
                check("b32_idle_hold", bus8.o_data, {32{16'd2}});
            end
        end

        // 8x8 IDCT stage1, S=12: saturation and rounding of negatives
        d = '0;
        d[27:0]    = 28'h7FFFFFF;
        d[55:28]   = 28'h8000000;
        d[83:56]   = 28'd2048;
        d[111:84]  = 28'hFFFF7FF;
        d[139:112] = 28'hFFFF800;
        drv8(1'b1, 1'b1, 1'b1, 2'd1, d);
        tick;
        drv8(1'b1, 1'b1, 1'b1, 2'd1, '0);
        tick;
        e = '0;
        e[79:0] = {16'h0000, 16'hffff, 16'h0001, 16'h8000, 16'h7fff};
        check("i8_data", bus8.o_data, e);
        flags8("i8_b0", 1'b1, 1'b0, 1'b0, 1'b1);
        drv8(1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick;
        check("i8_b1_data", bus8.o_data, '0);
        flags8("i8_b1", 1'b0, 1'b1, 1'b1, 1'b0);

        // 4x4 DCT stage1: upper lanes masked off
        d = '0;
        d[895:448] = {16{28'h7FFFFFF}};
        drv8(1'b1, 1'b0, 1'b1, 2'd0, d);
        tick;
        drv8(1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick;
        check("m4_data", bus8.o_data, '0);
        flags8("m4", 1'b1, 1'b1, 1'b1, 1'b0);

        // 16x16 DCT stage0 (S=3) with gaps and a mid-block transize change
        for (int c = 0; c < 12; c++) begin
            drv8(v_t[c], 1'b0, 1'b0, big_t[c] ? 2'd2 : 2'd0, {32{28'd20}});
            tick;
            if (c >= 1) begin
                check("b16_vld", bus8.o_dt_vld, v_t[c-1]);
                check("b16_first", bus8.o_first, f_t[c-1]);
                check("b16_last", bus8.o_last, l_t[c-1]);
                if (v_t[c-1]) check("b16_data", bus8.o_data, {32{16'd3}});
            end
        end

        // reset in the middle of a 32x32 block, then an 8x8 IDCT stage0 block (S=7)
        for (int i = 0; i < 5; i++) begin
            drv8(1'b1, 1'b0, 1'b0, 2'd3, {32{28'd24}});
            tick;
        end
        drv8(1'b0, 1'b0, 1'b0, 2'd0, '0);
        rst_n = 1'b0;
        #1;
        check("mrst_vld", bus8.o_dt_vld, 1'b0);
        check("mrst_data", bus8.o_data, '0);
        check("mrst_flags", {bus8.o_first, bus8.o_last, bus8.o_zero, bus8.o_sat}, 4'b0);
        tick;
        tick;
        check("mrst_hold_vld", bus8.o_dt_vld, 1'b0);
        rst_n = 1'b1;
        drv8(1'b1, 1'b1, 1'b0, 2'd1, {32{28'd128}});
        tick;
        check("post_drop", bus8.o_dt_vld, 1'b0);
        drv8(1'b1, 1'b1, 1'b0, 2'd1, {32{28'd128}});
        tick;
        check("post_b0_data", bus8.o_data, {32{16'd1}});
        flags8("post_b0", 1'b1, 1'b0, 1'b0, 1'b0);
        drv8(1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick;
        flags8("post_b1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        check("post_idle", bus8.o_dt_vld, 1'b0);

        // BIT_DEPTH=10: DCT stage0 4x4 (S=3), then IDCT stage1 (S=10)
        d = '0;
        d[27:0] = 28'd12;
        drv10(1'b1, 1'b0, 1'b0, 2'd0, d);
        tick;
        d[27:0] = 28'd511;
        drv10(1'b1, 1'b1, 1'b1, 2'd0, d);
        tick;
        e = '0;
        e[15:0] = 16'd2;
        check("bd10_dct_data", bus10.o_data, e);
        check("bd10_dct_fl", {bus10.o_dt_vld, bus10.o_first, bus10.o_last}, 3'b111);
        d[27:0] = 28'd512;
        drv10(1'b1, 1'b1, 1'b1, 2'd0, d);
        tick;
        check("bd10_511_data", bus10.o_data, '0);
        check("bd10_511_zero", bus10.o_zero, 1'b1);
        drv10(1'b0, 1'b0, 1'b0, 2'd0, '0);
        tick;
        e[15:0] = 16'd1;
        check("bd10_512_data", bus10.o_data, e);
        check("bd10_512_fl", {bus10.o_dt_vld, bus10.o_first, bus10.o_last, bus10.o_zero}, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
